// File: rtl/sticker_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : sticker_classifier
//  Purpose  : Reads the nine stored block colours of one cube face one by one
//             over an indexed read port, classifies each RGB triple into a
//             3-bit cube colour code and publishes a 27-bit face vector.
//  Ports    : Clk        - system clock
//             Reset      - synchronous, active-high reset
//             Start      - 1-cycle pulse, colours stored, begin a pass
//             Sel_idx    - [3:0] block index to the colour store (0 otherwise)
//             Sel_color  - [29:0] {R,G,B} of Sel_idx, valid one cycle later
//             Busy       - high from the cycle after Start through DONE
//             Done       - 1-cycle pulse, Face_codes complete
//             Face_codes - [26:0] sticker k at [3k+2:3k]
//             Face_err   - face plausibility flag (FACE_CHECK_EN builds only)
//  Config   : `define FACE_CHECK_EN builds the face check; otherwise
//             Face_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module sticker_classifier #(
  parameter logic [9:0] DARK_MAX   = 10'd96,
  parameter logic [9:0] CHROMA_MIN = 10'd80,
  parameter logic [9:0] WHITE_MIN  = 10'd512,
  parameter logic [9:0] YEL_DELTA  = 10'd160,
  parameter logic [9:0] ORG_DELTA  = 10'd96
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic [3:0]  Sel_idx,
  input  logic [29:0] Sel_color,
  output logic        Busy,
  output logic        Done,
  output logic [26:0] Face_codes,
  output logic        Face_err
);

  localparam logic [2:0] C_WHITE   = 3'd0;
  localparam logic [2:0] C_YELLOW  = 3'd1;
  localparam logic [2:0] C_ORANGE  = 3'd2;
  localparam logic [2:0] C_RED     = 3'd3;
  localparam logic [2:0] C_GREEN   = 3'd4;
  localparam logic [2:0] C_BLUE    = 3'd5;
  localparam logic [2:0] C_UNKNOWN = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CLASS = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [29:0] color_q, color_d;
  logic [26:0] face_codes_q, face_codes_d;

  // --------------------------------------------------------------------------
  // Classifier on the captured colour
  // --------------------------------------------------------------------------
  logic [9:0]  red, grn, blu;
  logic [9:0]  max_v, min_v;
  logic        r_is_max, g_is_max;
  logic [10:0] chroma;
  logic [2:0]  class_code;

  always_comb begin
    red = color_q[29:20];
    grn = color_q[19:10];
    blu = color_q[9:0];

    // Ties resolve toward R, then G, so equal R/G counts as a red-family hue.
    r_is_max = (red >= grn) && (red >= blu);
    g_is_max = !r_is_max && (grn >= blu);

    if (r_is_max)      max_v = red;
    else if (g_is_max) max_v = grn;
    else               max_v = blu;

    if ((red <= grn) && (red <= blu)) min_v = red;
    else if (grn <= blu)              min_v = grn;
    else                              min_v = blu;

    chroma = {1'b0, max_v} - {1'b0, min_v};

    // Deltas are added in 11 bits so saturated channels cannot wrap.
    if (max_v < DARK_MAX) begin
      class_code = C_UNKNOWN;
    end else if (chroma < {1'b0, CHROMA_MIN}) begin
      class_code = (min_v >= WHITE_MIN) ? C_WHITE : C_UNKNOWN;
    end else if (r_is_max) begin
      if (({1'b0, grn} + {1'b0, YEL_DELTA}) >= {1'b0, red})
        class_code = C_YELLOW;
      else if ({1'b0, grn} >= ({1'b0, blu} + {1'b0, ORG_DELTA}))
        class_code = C_ORANGE;
      else
        class_code = C_RED;
    end else if (g_is_max) begin
      class_code = C_GREEN;
    end else begin
      class_code = C_BLUE;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: FETCH drives the index, WAIT captures the returned colour,
  // CLASS writes the slot.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    color_d      = color_q;
    face_codes_d = face_codes_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          idx_d   = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        color_d = Sel_color;
        state_d = S_CLASS;
      end
      S_CLASS: begin
        for (int k = 0; k < 9; k++) begin
          if (idx_q == 4'(k)) face_codes_d[3*k +: 3] = class_code;
        end
        if (idx_q < 4'd8) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      color_q      <= 30'd0;
      face_codes_q <= {27{1'b1}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      color_q      <= color_d;
      face_codes_q <= face_codes_d;
    end
  end

  assign Sel_idx    = (state_q == S_FETCH) ? idx_q : 4'd0;
  assign Busy       = (state_q != S_IDLE);
  assign Done       = (state_q == S_DONE);
  assign Face_codes = face_codes_q;

  // --------------------------------------------------------------------------
  // Optional face check: evaluated on the completed vector so the flag is
  // valid in the same cycle as Done.
  // --------------------------------------------------------------------------
`ifdef FACE_CHECK_EN
  logic face_err_q, face_err_d;
  logic any_unknown;

  always_comb begin
    any_unknown = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (face_codes_d[3*k +: 3] == C_UNKNOWN) any_unknown = 1'b1;
    end
    face_err_d = face_err_q;
    if ((state_q == S_CLASS) && (idx_q == 4'd8))
      face_err_d = any_unknown || (face_codes_d[14:12] == C_UNKNOWN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) face_err_q <= 1'b0;
    else       face_err_q <= face_err_d;
  end

  assign Face_err = face_err_q;
`else
  assign Face_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sticker_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sticker_classifier
//  Purpose  : Directed self-checking bench for sticker_classifier with a
//             registered-read colour store model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sticker_classifier;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  Sel_idx;
  logic [29:0] Sel_color;
  logic        Busy;
  logic        Done;
  logic [26:0] Face_codes;
  logic        Face_err;

  sticker_classifier dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Sel_idx    (Sel_idx),
    .Sel_color  (Sel_color),
    .Busy       (Busy),
    .Done       (Done),
    .Face_codes (Face_codes),
    .Face_err   (Face_err)
  );

  always #5 Clk = ~Clk;

`ifdef FACE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // Colour store: registered read, data valid one cycle after the index.
  logic [29:0] mem [0:8];
  always @(posedge Clk) Sel_color <= (Sel_idx < 4'd9) ? mem[Sel_idx] : 30'd0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] rgb(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  task automatic fill(input logic [29:0] c);
    for (int i = 0; i < 9; i++) mem[i] = c;
  endtask

  // Pulse Start, then watch from cycle t+1 (k=1). Returns the k at which Done
  // is first seen, or -1 if it never appears within the budget.
  task automatic run_pass(input int restart_k, input int reset_k, output int lat);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) check_val("busy_after_start", 32'(Busy), 32'd1);
      if (reset_k == 0 && k == 4)  check_val("sel_idx_slot1", 32'(Sel_idx), 32'd1);
      if (reset_k == 0 && k == 25) check_val("sel_idx_slot8", 32'(Sel_idx), 32'd8);
      if (reset_k > 0 && k == reset_k + 1) begin
        check_val("rst_busy",  32'(Busy), 32'd0);
        check_val("rst_codes", 32'(Face_codes), 32'h7FFFFFF);
        check_val("rst_err",   32'(Face_err), 32'd0);
        check_val("rst_sel",   32'(Sel_idx), 32'd0);
      end
      if (Done) begin
        lat = k;
        break;
      end
      Start = (k == restart_k);
      Reset = (k == reset_k);
      @(negedge Clk);
    end
    Start = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic after_done_checks();
    @(negedge Clk);
    check_val("done_pulse", 32'(Done), 32'd0);
    check_val("busy_clear", 32'(Busy), 32'd0);
    check_val("sel_idle",   32'(Sel_idx), 32'd0);
  endtask

  logic [2:0] exp3 [0:8];
  int lat;

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    fill(rgb(900, 880, 870));
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Idle after reset
    repeat (10) @(negedge Clk);
    check_val("idle_codes", 32'(Face_codes), 32'h7FFFFFF);
    check_val("idle_busy",  32'(Busy), 32'd0);
    check_val("idle_done",  32'(Done), 32'd0);
    check_val("idle_sel",   32'(Sel_idx), 32'd0);
    check_val("idle_err",   32'(Face_err), 32'd0);

    // All white
    run_pass(0, 0, lat);
    check_val("white_lat",   32'(lat), 32'd28);
    check_val("white_codes", 32'(Face_codes), 32'h0);
    check_val("white_err",   32'(Face_err), 32'd0);
    after_done_checks();

    // Mixed hues
    mem[0] = rgb(800, 100, 100);
    mem[1] = rgb(800,  50, 400);
    mem[2] = rgb(800, 400, 100);
    mem[3] = rgb(800, 700, 100);
    mem[4] = rgb(100, 800, 100);
    mem[5] = rgb(100, 100, 800);
    mem[6] = rgb( 50,  40,  30);
    mem[7] = rgb(300, 300, 300);
    mem[8] = rgb(300, 300, 300);
    exp3 = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd4, 3'd5, 3'd7, 3'd7, 3'd7};
    run_pass(0, 0, lat);
    check_val("mix_lat", 32'(lat), 32'd28);
    for (int k = 0; k < 9; k++)
      check_val($sformatf("mix_slot%0d", k), 32'(Face_codes[3*k +: 3]), 32'(exp3[k]));
    check_val("mix_vec", 32'(Face_codes), 32'h7FEC29B);
    check_val("mix_err", 32'(Face_err), 32'(CHK_EN));
    after_done_checks();

    // Tie and saturated-channel cases
    fill(rgb(900, 880, 870));
    mem[0] = rgb(600, 600, 100);
    mem[1] = rgb(1023, 1023, 0);
    run_pass(0, 0, lat);
    check_val("tie_lat",   32'(lat), 32'd28);
    check_val("tie_slot0", 32'(Face_codes[2:0]), 32'd1);
    check_val("tie_slot1", 32'(Face_codes[5:3]), 32'd1);
    check_val("tie_vec",   32'(Face_codes), 32'h9);
    check_val("tie_err",   32'(Face_err), 32'd0);
    after_done_checks();

    // Start during a pass is ignored
    fill(rgb(900, 880, 870));
    run_pass(5, 0, lat);
    check_val("restart_lat",   32'(lat), 32'd28);
    check_val("restart_codes", 32'(Face_codes), 32'h0);
    after_done_checks();
    repeat (30) @(negedge Clk);
    check_val("restart_no_queue", 32'(Busy), 32'd0);

    // Reset mid-pass aborts, no Done
    run_pass(0, 10, lat);
    check_val("rst_no_done", 32'(lat), 32'hFFFFFFFF);

    // Dark centre slot
    fill(rgb(900, 880, 870));
    mem[4] = rgb(50, 40, 30);
    run_pass(0, 0, lat);
    check_val("dark_lat",   32'(lat), 32'd28);
    check_val("dark_codes", 32'(Face_codes), 32'h7000);
    check_val("dark_err",   32'(Face_err), 32'(CHK_EN));
    repeat (5) @(negedge Clk);
    check_val("dark_err_hold", 32'(Face_err), 32'(CHK_EN));
    check_val("dark_codes_hold", 32'(Face_codes), 32'h7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
